maze_vga_renderer: RTL and testbench

Frame renderer for the maze game: generates VGA raster timing, fetches one wall bit per tile from the maze map ROM, and drives 24-bit RGB plus syncs to the VGA DAC. It is the producer of the `fDrawDone` end-of-frame strobe consumed by the game top level, which advances player movement once per frame. It sits between the maze map ROM and the board VGA pins, next to the game controller.

---
 rtl/maze_vga_renderer.sv | 166 ++++++++++++++++
 tb/tb_maze_vga_renderer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_vga_renderer.sv
`default_nettype none
// ============================================================================
// Module      : maze_vga_renderer
// Description : VGA raster timing, per-tile maze wall lookup and RGB/sync drive
//               with a one-cycle end-of-frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_vga_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int TILE_SHIFT = 5,
    parameter int MAP_W      = 20
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] i_PlayerX,
    input  logic [3:0] i_PlayerY,
    input  logic [4:0] i_GoalX,
    input  logic [3:0] i_GoalY,
    output logic [8:0] o_MapAddr,
    input  logic       i_MapWall,
    output logic [7:0] o_Red,
    output logic [7:0] o_Green,
    output logic [7:0] o_Blue,
    output logic       o_hSync,
    output logic       o_vSync,
    output logic       o_fDrawDone
);

    localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HS_START = H_ACTIVE + H_FP;
    localparam int c_HS_END   = c_HS_START + H_SYNC - 1;
    localparam int c_VS_START = V_ACTIVE + V_FP;
    localparam int c_VS_END   = c_VS_START + V_SYNC - 1;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [4:0] r_player_x;
    logic [3:0] r_player_y;
    logic [4:0] r_goal_x;
    logic [3:0] r_goal_y;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_active;
    logic       w_last;
    logic [4:0] w_col;
    logic [4:0] w_row;
    logic [8:0] w_addr;
    logic       w_player_hit;
    logic       w_goal_hit;
    logic       w_hsync;
    logic       w_vsync;

    // Stage 1 / stage 2 carry registers; stage 2 lines up with i_MapWall.
    logic r_s1_active, r_s1_player, r_s1_goal, r_s1_hs, r_s1_vs, r_s1_done;
    logic r_s2_active, r_s2_player, r_s2_goal, r_s2_hs, r_s2_vs, r_s2_done;
    logic [23:0] w_rgb;

    assign w_h_wrap = (r_h_cnt == 10'(c_H_TOTAL - 1));
    assign w_v_wrap = (r_v_cnt == 10'(c_V_TOTAL - 1));
    assign w_active = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    assign w_last   = (r_h_cnt == 10'(H_ACTIVE - 1)) && (r_v_cnt == 10'(V_ACTIVE - 1));
    assign w_col    = 5'(r_h_cnt >> TILE_SHIFT);
    assign w_row    = 5'(r_v_cnt >> TILE_SHIFT);
    assign w_addr   = 9'(w_row) * 9'(MAP_W) + 9'(w_col);

    // Compared against the latched copies before the latch edge takes effect,
    // so the final pixel of a frame still uses the old positions.
    assign w_player_hit = (w_col == r_player_x) && (w_row == {1'b0, r_player_y});
    assign w_goal_hit   = (w_col == r_goal_x) && (w_row == {1'b0, r_goal_y});
    assign w_hsync = !((r_h_cnt >= 10'(c_HS_START)) && (r_h_cnt <= 10'(c_HS_END)));
    assign w_vsync = !((r_v_cnt >= 10'(c_VS_START)) && (r_v_cnt <= 10'(c_VS_END)));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_player_x <= '0;
            r_player_y <= '0;
            r_goal_x   <= '0;
            r_goal_y   <= '0;
        end else begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
            if (w_last) begin
                r_player_x <= i_PlayerX;
                r_player_y <= i_PlayerY;
                r_goal_x   <= i_GoalX;
                r_goal_y   <= i_GoalY;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_MapAddr   <= '0;
            r_s1_active <= 1'b0;
            r_s1_player <= 1'b0;
            r_s1_goal   <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_s1_done   <= 1'b0;
            r_s2_active <= 1'b0;
            r_s2_player <= 1'b0;
            r_s2_goal   <= 1'b0;
            r_s2_hs     <= 1'b1;
            r_s2_vs     <= 1'b1;
            r_s2_done   <= 1'b0;
        end else begin
            o_MapAddr   <= w_active ? w_addr : 9'd0;
            r_s1_active <= w_active;
            r_s1_player <= w_player_hit;
            r_s1_goal   <= w_goal_hit;
            r_s1_hs     <= w_hsync;
            r_s1_vs     <= w_vsync;
            r_s1_done   <= w_last;
            r_s2_active <= r_s1_active;
            r_s2_player <= r_s1_player;
            r_s2_goal   <= r_s1_goal;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
            r_s2_done   <= r_s1_done;
        end
    end

    always_comb begin
        w_rgb = 24'h000000;
        if (r_s2_active) begin
            if (r_s2_player)    w_rgb = 24'hFF0000;
            else if (r_s2_goal) w_rgb = 24'h00FF00;
            else if (i_MapWall) w_rgb = 24'hFFFFFF;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_Red       <= '0;
            o_Green     <= '0;
            o_Blue      <= '0;
            o_hSync     <= 1'b1;
            o_vSync     <= 1'b1;
            o_fDrawDone <= 1'b0;
        end else begin
            o_Red       <= w_rgb[23:16];
            o_Green     <= w_rgb[15:8];
            o_Blue      <= w_rgb[7:0];
            o_hSync     <= r_s2_hs;
            o_vSync     <= r_s2_vs;
            o_fDrawDone <= r_s2_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maze_vga_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_vga_renderer
// Description : Self-checking bench for maze_vga_renderer on a reduced raster
//               (40x28 total, 32x24 visible, 8 px tiles, 4x3 map).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_vga_renderer;

    localparam int c_HA = 32, c_HFP = 2, c_HS = 4, c_HBP = 2;
    localparam int c_VA = 24, c_VFP = 1, c_VS = 2, c_VBP = 1;
    localparam int c_HT = c_HA + c_HFP + c_HS + c_HBP;
    localparam int c_VT = c_VA + c_VFP + c_VS + c_VBP;
    localparam int c_FRAME = c_HT * c_VT;
    localparam int c_NV = 19;

    typedef struct packed {
        logic [4:0]  px;
        logic [3:0]  py;
        logic [4:0]  gx;
        logic [3:0]  gy;
        logic [8:0]  wall;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
        logic [2:0]  sig;   // {hSync, vSync, fDrawDone}
    } vec_t;

    logic       clk;
    logic       Rst;
    logic [4:0] player_x, goal_x;
    logic [3:0] player_y, goal_y;
    logic [8:0] map_addr;
    logic       map_wall;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, draw_done;
    logic [8:0] wall_addr;
    int         cyc;
    int         n_checks;
    int         n_fail;
    vec_t       vecs [c_NV];
    logic [23:0] rgb;

    assign rgb = {red, green, blue};

    maze_vga_renderer #(
        .H_ACTIVE(c_HA), .H_FP(c_HFP), .H_SYNC(c_HS), .H_BP(c_HBP),
        .V_ACTIVE(c_VA), .V_FP(c_VFP), .V_SYNC(c_VS), .V_BP(c_VBP),
        .TILE_SHIFT(3), .MAP_W(4)
    ) dut (
        .Clk(clk), .Rst(Rst),
        .i_PlayerX(player_x), .i_PlayerY(player_y),
        .i_GoalX(goal_x), .i_GoalY(goal_y),
        .o_MapAddr(map_addr), .i_MapWall(map_wall),
        .o_Red(red), .o_Green(green), .o_Blue(blue),
        .o_hSync(hsync), .o_vSync(vsync), .o_fDrawDone(draw_done)
    );

    always #5 clk = ~clk;

    // Synchronous map ROM: one wall tile at wall_addr.
    always @(posedge clk) map_wall <= (map_addr == wall_addr);

    // Edges since reset release; pixel p of frame f is on the pins at 3 + f*FRAME + p.
    always @(posedge clk or negedge Rst) begin
        if (!Rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int px, input int py, input int gx, input int gy,
                                input int wall, input int x, input int y,
                                input logic [23:0] exp_rgb, input logic [2:0] exp_sig);
        vec_t v;
        v.px = 5'(px); v.py = 4'(py); v.gx = 5'(gx); v.gy = 4'(gy);
        v.wall = 9'(wall); v.x = 8'(x); v.y = 8'(y);
        v.rgb = exp_rgb; v.sig = exp_sig;
        return v;
    endfunction

    task automatic do_reset(input int px, input int py, input int gx, input int gy, input int wall);
        @(negedge clk);
        Rst = 1'b0;
        player_x = 5'(px); player_y = 4'(py);
        goal_x = 5'(gx); goal_y = 4'(gy);
        wall_addr = 9'(wall);
        repeat (2) @(negedge clk);
        Rst = 1'b1;
    endtask

    task automatic wait_pixel(input int f, input int x, input int y);
        int target;
        int guard;
        target = 3 + f * c_FRAME + y * c_HT + x;
        guard = 0;
        while (cyc < target && guard < 4 * c_FRAME) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("pixel_reached f%0d (%0d,%0d)", f, x, y), cyc, target);
    endtask

    initial begin
        int red_n, green_n, white_n, done_n, done_wide, done_first;
        int hs_fall1, hs_fall2, hs_rise1, vs_fall1, vs_fall2, vs_rise1;
        logic prev_hs, prev_vs, prev_done;

        clk = 1'b0; Rst = 1'b0;
        player_x = '0; player_y = '0; goal_x = '0; goal_y = '0;
        wall_addr = 9'd15;
        n_checks = 0; n_fail = 0;

        vecs[0]  = mk(31, 0, 31, 0,  5,  8,  8, 24'hFFFFFF, 3'b110);
        vecs[1]  = mk(31, 0, 31, 0,  5, 15, 15, 24'hFFFFFF, 3'b110);
        vecs[2]  = mk(31, 0, 31, 0,  5, 16,  8, 24'h000000, 3'b110);
        vecs[3]  = mk(31, 0, 31, 0,  5,  7,  8, 24'h000000, 3'b110);
        vecs[4]  = mk(31, 0, 31, 0,  5,  8, 16, 24'h000000, 3'b110);
        vecs[5]  = mk(31, 0, 31, 0,  5,  8,  7, 24'h000000, 3'b110);
        vecs[6]  = mk( 1, 1,  1, 1,  5, 12, 12, 24'hFF0000, 3'b110);
        vecs[7]  = mk(31, 0,  1, 1,  5, 12, 12, 24'h00FF00, 3'b110);
        vecs[8]  = mk( 2, 0, 31, 0, 15, 16,  0, 24'hFF0000, 3'b110);
        vecs[9]  = mk( 2, 0, 31, 0, 15, 23,  7, 24'hFF0000, 3'b110);
        vecs[10] = mk( 2, 0, 31, 0, 15, 24,  0, 24'h000000, 3'b110);
        vecs[11] = mk(31, 0,  3, 2, 15, 31, 23, 24'h00FF00, 3'b111);
        vecs[12] = mk( 4, 0, 31, 0, 15, 32,  0, 24'h000000, 3'b110);
        vecs[13] = mk( 0, 3, 31, 0, 15,  0, 24, 24'h000000, 3'b110);
        vecs[14] = mk(31, 0, 31, 0, 15, 34,  0, 24'h000000, 3'b010);
        vecs[15] = mk(31, 0, 31, 0, 15, 37, 25, 24'h000000, 3'b000);
        vecs[16] = mk(31, 0, 31, 0,  0, 38,  0, 24'h000000, 3'b110);
        vecs[17] = mk(31, 0, 31, 0,  0,  0,  0, 24'hFFFFFF, 3'b110);
        vecs[18] = mk(31, 0, 31, 0, 15,  0, 25, 24'h000000, 3'b100);

        for (int i = 0; i < c_NV; i++) begin
            do_reset(int'(vecs[i].px), int'(vecs[i].py), int'(vecs[i].gx),
                     int'(vecs[i].gy), int'(vecs[i].wall));
            wait_pixel(1, int'(vecs[i].x), int'(vecs[i].y));
            check($sformatf("vec%0d rgb", i), 32'(rgb), 32'(vecs[i].rgb));
            check($sformatf("vec%0d sync/done", i), 32'({hsync, vsync, draw_done}), 32'(vecs[i].sig));
        end

        // Mid-frame position change only shows up in the following frame.
        do_reset(1, 2, 31, 0, 15);
        wait_pixel(1, 0, 12);
        player_x = 5'd2;
        wait_pixel(1, 8, 16);
        check("latch old tile f1", 32'(rgb), 32'hFF0000);
        wait_pixel(1, 16, 16);
        check("latch new tile f1", 32'(rgb), 32'h000000);
        wait_pixel(2, 8, 16);
        check("latch old tile f2", 32'(rgb), 32'h000000);
        wait_pixel(2, 16, 16);
        check("latch new tile f2", 32'(rgb), 32'hFF0000);

        // Off-grid player and goal draw nothing for a whole frame.
        do_reset(25, 1, 1, 7, 15);
        wait_pixel(1, 0, 0);
        red_n = 0; green_n = 0; done_n = 0;
        for (int k = 0; k < c_FRAME; k++) begin
            if (rgb == 24'hFF0000) red_n++;
            if (rgb == 24'h00FF00) green_n++;
            if (draw_done) done_n++;
            @(negedge clk);
        end
        check("offgrid red pixels", red_n, 0);
        check("offgrid green pixels", green_n, 0);
        check("offgrid done pulses", done_n, 1);

        // Reset while the end-of-frame strobe is still in the pipeline.
        do_reset(3, 2, 31, 0, 15);
        wait_pixel(1, 29, 23);
        check("pre-reset red", 32'(rgb), 32'hFF0000);
        #1 Rst = 1'b0;
        #1;
        check("async reset rgb", 32'(rgb), 32'h0);
        check("async reset syncs/done", 32'({hsync, vsync, draw_done}), 32'b110);
        check("async reset map addr", 32'(map_addr), 32'h0);
        player_x = 5'd31; player_y = 4'd0; goal_x = 5'd31; goal_y = 4'd0;
        wall_addr = 9'd5;
        done_n = 0;
        repeat (3) begin
            @(negedge clk);
            if (draw_done) done_n++;
        end
        Rst = 1'b1;

        red_n = 0; green_n = 0; white_n = 0; done_wide = 0; done_first = -1;
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
        vs_fall1 = -1; vs_fall2 = -1; vs_rise1 = -1;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_done = 1'b0;
        while (cyc < 3 + 3 * c_FRAME + 10) begin
            @(negedge clk);
            if (cyc == 328) check("map addr (7,8)", 32'(map_addr), 32'd4);
            if (cyc == 329) check("map addr (8,8)", 32'(map_addr), 32'd5);
            if (cyc == 353) check("map addr blank", 32'(map_addr), 32'd0);
            if (cyc == 952) check("map addr (31,23)", 32'(map_addr), 32'd11);
            if (cyc >= 3 && cyc < 3 + c_FRAME && rgb == 24'hFF0000) red_n++;
            if (cyc >= 3 + c_FRAME && cyc < 3 + 2 * c_FRAME) begin
                if (rgb == 24'hFFFFFF) white_n++;
                if (rgb == 24'h00FF00) green_n++;
            end
            if (prev_hs && !hsync) begin
                if (hs_fall1 < 0) hs_fall1 = cyc;
                else if (hs_fall2 < 0) hs_fall2 = cyc;
            end
            if (!prev_hs && hsync && hs_rise1 < 0) hs_rise1 = cyc;
            if (prev_vs && !vsync) begin
                if (vs_fall1 < 0) vs_fall1 = cyc;
                else if (vs_fall2 < 0) vs_fall2 = cyc;
            end
            if (!prev_vs && vsync && vs_rise1 < 0) vs_rise1 = cyc;
            if (draw_done) begin
                done_n++;
                if (done_first < 0) done_first = cyc;
                if (prev_done) done_wide++;
            end
            prev_hs = hsync; prev_vs = vsync; prev_done = draw_done;
        end

        check("first done after release", done_first, 3 + (c_VA - 1) * c_HT + c_HA - 1);
        check("done pulses in 3 frames", done_n, 3);
        check("done multi-cycle pulses", done_wide, 0);
        check("hsync first fall", hs_fall1, 3 + c_HA + c_HFP);
        check("hsync period", hs_fall2 - hs_fall1, c_HT);
        check("hsync width", hs_rise1 - hs_fall1, c_HS);
        check("vsync first fall", vs_fall1, 3 + (c_VA + c_VFP) * c_HT);
        check("vsync period", vs_fall2 - vs_fall1, c_FRAME);
        check("vsync width", vs_rise1 - vs_fall1, c_VS * c_HT);
        check("reset-latched player tile pixels f0", red_n, 64);
        check("wall tile pixels f1", white_n, 64);
        check("green pixels f1", green_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
